video_timing_scanout: RTL and testbench



---
 rtl/video_timing_scanout.sv | 146 ++++++++++++++
 tb/tb_video_timing_scanout.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_scanout.sv
// Raster timing generator and scanout stage feeding the RGB565->YCbCr converter.
// Latency: every output is registered one cycle after the counter state it reflects.
// Backpressure: none. pixel_ready follows the active region and never waits for data;
//   a missing pixel is replaced by UNDERFLOW_COLOR, counted, and the raster keeps running.
//
// Ports:
//   clk_pixel        pixel clock (only clock)
//   rst              asynchronous active-high reset
//   pixel_data       RGB565 word from the framebuffer read FIFO
//   pixel_valid      pixel_data holds a word
//   pixel_ready      word is taken this cycle when pixel_valid=1 (combinational)
//   underflow_clear  synchronous clear of underflow_flag/underflow_count
//   rgb565_out       pixel to the converter (0 in blanking)
//   data_enable_out  active video
//   hsync_out        horizontal sync, asserted level HSYNC_POL
//   vsync_out        vertical sync, asserted level VSYNC_POL
//   vblank_start     one-cycle pulse at the first blanking pixel after the last active line
//   underflow_flag   sticky underflow indicator
//   underflow_count  saturating count of underflowed pixels
module video_timing_scanout #(
  parameter int          H_ACTIVE        = 1280,
  parameter int          H_FP            = 110,
  parameter int          H_SYNC          = 40,
  parameter int          H_BP            = 220,
  parameter int          V_ACTIVE        = 720,
  parameter int          V_FP            = 5,
  parameter int          V_SYNC          = 5,
  parameter int          V_BP            = 20,
  parameter bit          HSYNC_POL       = 1'b1,
  parameter bit          VSYNC_POL       = 1'b1,
  parameter logic [15:0] UNDERFLOW_COLOR = 16'hF81F
) (
  input  logic        clk_pixel,
  input  logic        rst,
  input  logic [15:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  input  logic        underflow_clear,
  output logic [15:0] rgb565_out,
  output logic        data_enable_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        vblank_start,
  output logic        underflow_flag,
  output logic [15:0] underflow_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  // Counters widened to 32 bits so region compares against int parameters
  // are width-clean even when a boundary equals the total.
  logic [31:0] h_pos;
  logic [31:0] v_pos;

  logic h_last;
  logic v_last;
  logic active;
  logic in_hsync;
  logic in_vsync;
  logic at_vblank;
  logic underflow;

  assign h_pos = 32'(h_cnt);
  assign v_pos = 32'(v_cnt);

  always_comb begin
    h_last    = (h_pos == H_TOTAL - 1);
    v_last    = (v_pos == V_TOTAL - 1);
    active    = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
    in_hsync  = (h_pos >= H_SYNC_START) && (h_pos < H_SYNC_END);
    // Vertical region depends on v_cnt only, so vsync edges fall on h_cnt=0.
    in_vsync  = (v_pos >= V_SYNC_START) && (v_pos < V_SYNC_END);
    at_vblank = (h_pos == 0) && (v_pos == V_ACTIVE);
    underflow = active && !pixel_valid;
  end

  // Held low while in reset so the FIFO cannot pop a word the raster will
  // never show; otherwise it tracks the active region only.
  assign pixel_ready = active && !rst;

  // Raster counters: h wraps every line, v advances on the h wrap.
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      if (v_last) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + 1'b1;
      end
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Registered video outputs, one cycle behind the counters.
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      rgb565_out      <= 16'h0000;
      data_enable_out <= 1'b0;
      hsync_out       <= ~HSYNC_POL;
      vsync_out       <= ~VSYNC_POL;
      vblank_start    <= 1'b0;
    end else begin
      data_enable_out <= active;
      hsync_out       <= in_hsync ? HSYNC_POL : ~HSYNC_POL;
      vsync_out       <= in_vsync ? VSYNC_POL : ~VSYNC_POL;
      vblank_start    <= at_vblank;
      if (active) begin
        rgb565_out <= pixel_valid ? pixel_data : UNDERFLOW_COLOR;
      end else begin
        rgb565_out <= 16'h0000;
      end
    end
  end

  // Underflow bookkeeping; a clear wins over an underflow in the same cycle.
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      underflow_flag  <= 1'b0;
      underflow_count <= 16'h0000;
    end else if (underflow_clear) begin
      underflow_flag  <= 1'b0;
      underflow_count <= 16'h0000;
    end else if (underflow) begin
      underflow_flag <= 1'b1;
      if (underflow_count != 16'hFFFF) begin
        underflow_count <= underflow_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_scanout.sv
// Scoreboard bench for video_timing_scanout with a small raster (16x8, 128-cycle frame).
// The driver pushes expected output records as it presents each pixel; a monitor
// pops and compares them one clock later, and pops pixels on data_enable_out.
module tb_video_timing_scanout;

  localparam logic [15:0] UF = 16'hF81F;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        vb;
    logic        flag;
    logic [15:0] cnt;
  } rec_t;

  logic        clk_pixel = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pixel_data = 16'h0000;
  logic        pixel_valid = 1'b1;
  logic        pixel_ready;
  logic        underflow_clear = 1'b0;
  logic [15:0] rgb565_out;
  logic        data_enable_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        vblank_start;
  logic        underflow_flag;
  logic [15:0] underflow_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Bench-side raster/FIFO model.
  int          tb_h = 0;
  int          tb_v = 0;
  logic [15:0] word = 16'h0001;
  logic        m_flag = 1'b0;
  logic [15:0] m_cnt = 16'h0000;
  int          takes = 0;
  bit          drop_all = 1'b0;
  bit          drop_one = 1'b0;
  int          drop_h = 0;
  int          drop_v = 0;

  rec_t        tq[$];
  logic [15:0] pq[$];

  always #5 clk_pixel = ~clk_pixel;

  video_timing_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .UNDERFLOW_COLOR(16'hF81F)
  ) dut (
    .clk_pixel(clk_pixel),
    .rst(rst),
    .pixel_data(pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .underflow_clear(underflow_clear),
    .rgb565_out(rgb565_out),
    .data_enable_out(data_enable_out),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out),
    .vblank_start(vblank_start),
    .underflow_flag(underflow_flag),
    .underflow_count(underflow_count)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
    cyc++;
  endtask

  // Driver: presents the pixel for the model position and pushes expectations.
  always @(negedge clk_pixel) begin
    if (!rst) begin
      bit   act;
      bit   v;
      rec_t r;
      act = (tb_h < 8) && (tb_v < 4);
      v = !(drop_all || (drop_one && tb_v == drop_v && tb_h == drop_h));
      if (drop_one && act && tb_v == drop_v && tb_h == drop_h) drop_one = 1'b0;
      chk("pixel_ready", pixel_ready, act);
      pixel_valid = v;
      pixel_data  = word;
      if (pixel_ready && v) takes++;
      if (act) begin
        pq.push_back(v ? word : UF);
        if (v) word = word + 16'd1;
      end
      if (underflow_clear) begin
        m_flag = 1'b0;
        m_cnt  = 16'h0000;
      end else if (act && !v) begin
        m_flag = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      r.de   = act;
      r.hs   = (tb_h >= 10) && (tb_h < 13);
      r.vs   = (tb_v >= 5) && (tb_v < 7);
      r.vb   = (tb_h == 0) && (tb_v == 4);
      r.flag = m_flag;
      r.cnt  = m_cnt;
      tq.push_back(r);
      if (tb_h == 15) begin
        tb_h = 0;
        tb_v = (tb_v == 7) ? 0 : tb_v + 1;
      end else begin
        tb_h = tb_h + 1;
      end
    end
  end

  // Monitor: one record per clock, one pixel per data_enable_out.
  always @(posedge clk_pixel) begin
    rec_t        r;
    logic [15:0] e;
    #1;
    if (!rst && tq.size() > 0) begin
      r = tq.pop_front();
      chk("de", data_enable_out, r.de);
      chk("hsync", hsync_out, r.hs);
      chk("vsync", vsync_out, r.vs);
      chk("vblank", vblank_start, r.vb);
      chk("uf_flag", underflow_flag, r.flag);
      chk("uf_count", underflow_count, r.cnt);
      if (data_enable_out) begin
        if (pq.size() == 0) begin
          chk("pixel_queue_nonempty", 0, 1);
        end else begin
          e = pq.pop_front();
          chk("pixel", rgb565_out, e);
        end
      end else begin
        chk("rgb_blank", rgb565_out, 16'h0000);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rgb"}, rgb565_out, 16'h0000);
    chk({tag, "_de"}, data_enable_out, 1'b0);
    chk({tag, "_hsync"}, hsync_out, 1'b0);
    chk({tag, "_vsync"}, vsync_out, 1'b0);
    chk({tag, "_vblank"}, vblank_start, 1'b0);
    chk({tag, "_flag"}, underflow_flag, 1'b0);
    chk({tag, "_count"}, underflow_count, 16'h0000);
    chk({tag, "_ready"}, pixel_ready, 1'b0);
  endtask

  initial begin
    int hs_first;
    int hs_n;
    int vs_first;
    int vs_n;
    int vb_c[$];
    hs_first = -1; hs_n = 0; vs_first = -1; vs_n = 0;

    // Reset state.
    repeat (2) @(posedge clk_pixel);
    #2;
    chk_reset_vals("reset");
    rst = 1'b0;

    // Two frames with a continuously valid FIFO.
    for (int i = 0; i < 256; i++) begin
      tick();
      if (cyc == 1) chk("line0_px1", rgb565_out, 16'h0001);
      if (cyc == 8) chk("line0_px8", rgb565_out, 16'h0008);
      if (cyc == 9) chk("line0_de_fall", data_enable_out, 1'b0);
      if (cyc <= 16 && hsync_out) begin
        if (hs_first < 0) hs_first = cyc;
        hs_n++;
      end
      if (cyc <= 128 && vsync_out) begin
        if (vs_first < 0) vs_first = cyc;
        vs_n++;
      end
      if (vblank_start) vb_c.push_back(cyc);
      if (cyc == 128) chk("words_frame0", takes, 32);
    end
    chk("words_2frames", takes, 64);
    chk("hsync_first", hs_first, 11);
    chk("hsync_len", hs_n, 3);
    chk("vsync_first", vs_first, 81);
    chk("vsync_len", vs_n, 32);
    chk("vblank_pulses", vb_c.size(), 2);
    if (vb_c.size() == 2) begin
      chk("vblank_first", vb_c[0], 65);
      chk("vblank_period", vb_c[1] - vb_c[0], 128);
    end

    // Single underflow at pixel 3 of line 1 in frame 2.
    drop_v = 1; drop_h = 3; drop_one = 1'b1;
    while (cyc < 380) begin
      tick();
      if (cyc == 275) chk("pre_drop_flag", underflow_flag, 1'b0);
      if (cyc == 276) begin
        chk("drop_rgb", rgb565_out, UF);
        chk("drop_flag", underflow_flag, 1'b1);
        chk("drop_count", underflow_count, 16'd1);
      end
      if (cyc == 277) chk("held_word", rgb565_out, 16'h004C);
    end

    // Clear in blanking, then a whole frame of underflow.
    underflow_clear = 1'b1;
    tick();
    underflow_clear = 1'b0;
    chk("clear_flag", underflow_flag, 1'b0);
    chk("clear_count", underflow_count, 16'd0);
    drop_all = 1'b1;
    while (cyc < 480) tick();
    chk("frame_uf_count", underflow_count, 16'd32);
    chk("frame_uf_flag", underflow_flag, 1'b1);
    while (cyc < 512) tick();
    underflow_clear = 1'b1;
    tick();
    underflow_clear = 1'b0;
    chk("clear_wins_count", underflow_count, 16'd0);
    chk("clear_wins_flag", underflow_flag, 1'b0);
    tick();
    chk("after_clear_count", underflow_count, 16'd1);
    drop_all = 1'b0;

    // Saturation from 16'hFFFE.
    while (cyc < 580) tick();
    #3;
    force dut.underflow_count = 16'hFFFE;
    m_cnt = 16'hFFFE;
    tick();
    #3;
    release dut.underflow_count;
    tick();
    chk("preset_count", underflow_count, 16'hFFFE);
    while (cyc < 639) tick();
    drop_all = 1'b1;
    while (cyc < 643) begin
      tick();
      if (cyc == 641) chk("sat_first", underflow_count, 16'hFFFF);
    end
    chk("sat_hold", underflow_count, 16'hFFFF);
    drop_all = 1'b0;

    // Asynchronous reset at line 2, pixel 5.
    while (cyc < 677) tick();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("midreset");
    tq.delete();
    pq.delete();
    tb_h = 0; tb_v = 0;
    m_flag = 1'b0; m_cnt = 16'h0000;
    word = 16'h0100;
    vb_c.delete();
    repeat (3) @(posedge clk_pixel);
    #2;
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 130; i++) begin
      tick();
      if (cyc == 1) begin
        chk("restart_de", data_enable_out, 1'b1);
        chk("restart_px", rgb565_out, 16'h0100);
      end
      if (vblank_start) vb_c.push_back(cyc);
    end
    chk("restart_vblank_n", vb_c.size(), 1);
    if (vb_c.size() > 0) chk("restart_vblank_at", vb_c[0], 65);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
